// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared geometry and loader state encoding for memory and loader
package imem_loader_pkg;
  localparam int XLEN = 32;
  localparam int DEPTH = 1024;
  localparam int ADDR_W = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction memory write port
interface imem_loader_if import imem_loader_pkg::*; #(parameter int AW = ADDR_W) ();
  logic in_valid;
  logic in_ready;
  logic [7:0] in_byte;
  logic mem_we;
  logic [AW-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  modport master (input in_valid, in_byte, output in_ready, mem_we, mem_addr, mem_wdata);
  modport slave (output in_valid, in_byte, input in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader_word_packer.sv
// word_packer: collects four bytes little-endian into one instruction word
module word_packer import imem_loader_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic push,
  input  logic [7:0] din,
  output logic [XLEN-1:0] word,
  output logic full
);
  logic [1:0] idx;
  assign full = idx == 2'd3;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      word <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (push) begin
      word[{idx, 3'b000} +: 8] <= din;
      idx <= idx + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream while holding the core
module imem_loader import imem_loader_pkg::*; #(
  parameter int DEPTH = imem_loader_pkg::DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [ADDR_W:0] word_count,
  output logic busy,
  output logic cpu_hold,
  output logic done,
  output logic err,
  imem_loader_if.master bus
);
  localparam logic [ADDR_W:0] max_words = (ADDR_W+1)'(DEPTH);
  state_t state;
  logic [ADDR_W:0] words_left;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0] word;
  logic clear, push, full, last;
  assign clear = state == IDLE && start;
  assign push = bus.in_valid && bus.in_ready;
  assign last = words_left == (ADDR_W+1)'(1);
  assign cpu_hold = busy;
  assign bus.mem_addr = addr;
  assign bus.mem_wdata = word;
  word_packer u_packer (
    .clk(clk), .rst_n(rst_n), .clear(clear), .push(push),
    .din(bus.in_byte), .word(word), .full(full)
  );
  // addr holds on the final write so mem_addr never wraps past DEPTH-1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      words_left <= '0;
      addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      bus.in_ready <= 1'b0;
      bus.mem_we <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      bus.mem_we <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (word_count == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else if (word_count > max_words) begin
            err <= 1'b1;
          end else begin
            state <= RECV;
            words_left <= word_count;
            addr <= '0;
            busy <= 1'b1;
            bus.in_ready <= 1'b1;
          end
        end
        RECV: if (push && full) begin
          state <= WRITE;
          bus.mem_we <= 1'b1;
          bus.in_ready <= 1'b0;
        end
        WRITE: begin
          state <= last ? DONE : RECV;
          done <= last;
          busy <= !last;
          bus.in_ready <= !last;
          addr <= last ? addr : addr + 1'b1;
          words_left <= words_left - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the word-indexed instruction memory from a byte stream before the core runs. It accepts bytes over a valid/ready handshake, packs four bytes little-endian into a 32-bit instruction, and drives a single-cycle write port into the instruction memory array at incrementing word addresses. While a load is in progress it asserts `cpu_hold` so the non-pipelined core stays stalled and does not fetch from a partially written memory.

## Interface
- `DEPTH`, 1024, number of 32-bit words in the instruction memory.
- `ADDR_W`, 10, word-address width, equal to clog2(`DEPTH`).
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request a load session; sampled only in IDLE.
- `word_count`  in  ADDR_W+1  number of words to load, latched on an accepted `start`.
- `in_valid`  in  1  byte source has data.
- `in_byte`  in  8  byte data.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction memory write enable.
- `mem_addr`  out  ADDR_W  word index written.
- `mem_wdata`  out  32  instruction word written.
- `busy`  out  1  session in progress (RECV or WRITE).
- `cpu_hold`  out  1  core stall; equal to `busy`.
- `done`  out  1  one-cycle pulse at session end.
- `err`  out  1  one-cycle pulse on a rejected `start`.

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: `in_ready`=0. On `start`:
  - `word_count`=0 → DONE (no writes).
  - `word_count`>`DEPTH` → `err` pulse next cycle, stay IDLE.
  - otherwise latch count into `words_left`, `addr`=0, `byte_idx`=0, → RECV.
- RECV: `in_ready`=1. A byte is accepted when `in_valid`&&`in_ready`; it is stored at bits [8*`byte_idx`+7 : 8*`byte_idx`] (first byte → [7:0]); `byte_idx` increments mod 4. Acceptance of byte 3 → WRITE.
- WRITE: `in_ready`=0, `mem_we`=1 for exactly this cycle, `mem_addr`=`addr`, `mem_wdata`=packed word. Then `addr`+1, `words_left`−1; if `words_left` was 1 → DONE, else → RECV.
- DONE: `done`=1 for one cycle, → IDLE. `addr` and packed buffer retain last values.
- `start` outside IDLE ignored; no restart or abort except reset.
- `mem_addr` never wraps: the `DEPTH` check guarantees the last write is at `DEPTH`−1.
- `mem_addr`/`mem_wdata` are don't-care when `mem_we`=0, but are held registered (no glitching).

## Timing
- All outputs registered or decoded from state; reset value of every output is 0 (`in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `busy`, `cpu_hold`, `done`, `err`).
- `start` in cycle N → `busy`/`in_ready` high in N+1.
- Minimum 5 cycles per word (4 accepts + 1 write); `in_valid` gaps stall RECV with no timeout.
- Byte 3 accepted in cycle N → `mem_we` high in N+1; `in_ready` low in N+1, high again in N+2 if words remain.
- Last write in cycle N → `done` high in N+1, `busy`/`cpu_hold` low in N+1, IDLE in N+2 (`start` accepted from N+2).
- `word_count`=0: `start` in N → `done` in N+1, `busy` never high.
- `rst_n`=0 mid-session: next edge → IDLE, all outputs 0, partial word discarded; words already written remain in memory.

## Structure
- Shared package: state enum (IDLE/RECV/WRITE/DONE), `XLEN`=32, default `DEPTH`/`ADDR_W`, so the memory and loader agree on geometry.
- One sub-module is natural: `word_packer` (byte index counter + 32-bit shift/insert register, `clear`, `push`, `full` outputs); FSM, address counter and word counter stay in `imem_loader`.

## Test plan
- Load 1 word, bytes 0xB3,0x82,0x21,0x40 back-to-back → one `mem_we` pulse, `mem_addr`=0, `mem_wdata`=0x402182B3, `done` one cycle later.
- Load 3 words with random `in_valid` gaps → writes at addr 0,1,2 with correct words, `cpu_hold` high throughout, no `in_ready` during WRITE.
- `word_count`=0 → `done` next cycle, no `mem_we`, `busy` stays 0; `word_count`=1025 → `err` pulse, no `busy`.
- Load `DEPTH` words → last write at `mem_addr`=1023, no wrap, `done` pulse once.
- Assert `rst_n`=0 after 2 bytes of word 1 → all outputs 0 next cycle; new `start` with 1 word writes addr 0 with the fresh bytes only.
- `start` pulsed during RECV → ignored; session count and addresses unchanged.
